// File: rtl/ccd_delay_pkg.sv
// Shared types and constants for the CCD delay tracker: FSM states, step-direction encoding and
// the tap-index width helper.
package ccd_delay_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDwell,
    StDecide
  } ccd_state_e;

  // Direction bit matches ccd_sign: 0 = net up events (step +1), 1 = net down events (step -1).
  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  function automatic int unsigned tap_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ccd_tap_line.sv
// Tapped delay line for x2: a DEPTH-long shift register with two adjacent registered taps,
// giving x2 delayed by tap+1 and tap+2 clocks.
module ccd_tap_line
  import ccd_delay_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned TapW = tap_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            x2_k,
  input  logic [TapW-1:0] tap,
  output logic            x2_k_delayed,
  output logic            x2_k_delayed_minus_1
);

  logic [DEPTH-1:0] sr_q, sr_d;
  logic             dly_q, dly_d;
  logic             dly_m1_q, dly_m1_d;

  // Tap never exceeds DEPTH-2, so tap+1 always lands inside the line.
  always_comb begin
    sr_d     = {sr_q[DEPTH-2:0], x2_k};
    dly_d    = sr_q[tap];
    dly_m1_d = sr_q[tap + TapW'(1)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      dly_q    <= 1'b0;
      dly_m1_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      dly_q    <= dly_d;
      dly_m1_q <= dly_m1_d;
    end
  end

  assign x2_k_delayed         = dly_q;
  assign x2_k_delayed_minus_1 = dly_m1_q;

endmodule

// File: rtl/ccd_delay_tracker.sv
// CCD transmit-side tracker: delays x2 through a tapped line and steers the tap one step per
// dwell window from the CCD sign, reporting saturation and lock on sustained reversals.
module ccd_delay_tracker
  import ccd_delay_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned TAP_INIT = 32,
  parameter int unsigned DWELL    = 1024,
  parameter int unsigned LOCK_CNT = 8,
  localparam int unsigned TapW    = tap_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            x2_k,
  input  logic            ccd_sign,
  output logic            x2_k_delayed,
  output logic            x2_k_delayed_minus_1,
  output logic            ccd_clr,
  output logic [TapW-1:0] tap,
  output logic            locked,
  output logic            sat
);

  localparam int unsigned CntW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int unsigned RevW = $clog2(LOCK_CNT + 1);

  ccd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TapW-1:0] tap_q, tap_d;
  logic [RevW-1:0] rev_q, rev_d;
  logic            last_dir_q, last_dir_d;
  logic            ccd_clr_q, ccd_clr_d;
  logic            locked_q, locked_d;
  logic            sat_q, sat_d;
  logic            dir;
  logic            blocked;

  ccd_tap_line #(
    .DEPTH(DEPTH)
  ) u_tap_line (
    .clk                 (clk),
    .rst                 (rst),
    .x2_k                (x2_k),
    .tap                 (tap_q),
    .x2_k_delayed        (x2_k_delayed),
    .x2_k_delayed_minus_1(x2_k_delayed_minus_1)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tap_d      = tap_q;
    rev_d      = rev_q;
    last_dir_d = last_dir_q;
    sat_d      = 1'b0;
    dir        = ccd_sign ? DirDown : DirUp;
    blocked    = (dir == DirUp) ? (tap_q == TapW'(DEPTH - 2)) : (tap_q == '0);

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StClear;
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StDwell;
      end
      StDwell: begin
        // DWELL-1 clocks here, so CLEAR + DWELL + DECIDE spans DWELL+1 clocks.
        if (cnt_q == CntW'(DWELL - 2)) begin
          state_d = StDecide;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecide: begin
        state_d = StClear;
        if (blocked) begin
          sat_d = 1'b1;
          rev_d = '0;
        end else begin
          tap_d      = (dir == DirUp) ? tap_q + TapW'(1) : tap_q - TapW'(1);
          last_dir_d = dir;
          if (dir != last_dir_q) begin
            rev_d = (rev_q == RevW'(LOCK_CNT)) ? rev_q : rev_q + RevW'(1);
          end else begin
            rev_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping en abandons the window: no step, lock history discarded, tap kept.
    if (!en) begin
      state_d    = StIdle;
      cnt_d      = cnt_q;
      tap_d      = tap_q;
      rev_d      = '0;
      last_dir_d = last_dir_q;
      sat_d      = 1'b0;
    end

    ccd_clr_d = (state_d == StIdle) || (state_d == StClear);
    locked_d  = en && (rev_q == RevW'(LOCK_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tap_q      <= TapW'(TAP_INIT);
      rev_q      <= '0;
      last_dir_q <= DirUp;
      ccd_clr_q  <= 1'b1;
      locked_q   <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
      rev_q      <= rev_d;
      last_dir_q <= last_dir_d;
      ccd_clr_q  <= ccd_clr_d;
      locked_q   <= locked_d;
      sat_q      <= sat_d;
    end
  end

  assign ccd_clr = ccd_clr_q;
  assign tap     = tap_q;
  assign locked  = locked_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_ccd_delay_tracker.sv
// Directed bench for ccd_delay_tracker with DWELL=4 (5-clock decision windows).
module tb_ccd_delay_tracker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       x2_k;
  logic       ccd_sign;
  logic       x2_k_delayed;
  logic       x2_k_delayed_minus_1;
  logic       ccd_clr;
  logic [5:0] tap;
  logic       locked;
  logic       sat;

  int n_checks = 0;
  int n_errors = 0;

  ccd_delay_tracker #(
    .DEPTH   (64),
    .TAP_INIT(32),
    .DWELL   (4),
    .LOCK_CNT(8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .x2_k                (x2_k),
    .ccd_sign            (ccd_sign),
    .x2_k_delayed        (x2_k_delayed),
    .x2_k_delayed_minus_1(x2_k_delayed_minus_1),
    .ccd_clr             (ccd_clr),
    .tap                 (tap),
    .locked              (locked),
    .sat                 (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entered with the DUT in CLEAR; leaves it in the following CLEAR.
  task automatic run_window(input logic sign, input int exp_tap, input logic exp_sat,
                            input logic exp_lock, input string tag);
    ccd_sign = sign;
    tick();
    check_eq({tag, "_clr_dwell"}, 32'(ccd_clr), 32'd0);
    check_eq({tag, "_sat_low"}, 32'(sat), 32'd0);
    tick();
    check_eq({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    tick();
    tick();
    check_eq({tag, "_clr_decide"}, 32'(ccd_clr), 32'd0);
    tick();
    check_eq({tag, "_clr_clear"}, 32'(ccd_clr), 32'd1);
    check_eq({tag, "_tap"}, 32'(tap), 32'(exp_tap));
    check_eq({tag, "_sat"}, 32'(sat), 32'(exp_sat));
  endtask

  initial begin
    int first_d;
    int first_m1;
    rst      = 1'b0;
    en       = 1'b0;
    x2_k     = 1'b0;
    ccd_sign = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_tap", 32'(tap), 32'd32);
    check_eq("rst_clr", 32'(ccd_clr), 32'd1);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_sat", 32'(sat), 32'd0);
    check_eq("rst_dly", 32'(x2_k_delayed), 32'd0);
    check_eq("rst_dly_m1", 32'(x2_k_delayed_minus_1), 32'd0);

    // 1: single pulse through the line with tracking disabled
    x2_k = 1'b1;
    tick();
    x2_k     = 1'b0;
    first_d  = -1;
    first_m1 = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (x2_k_delayed && first_d < 0) first_d = i;
      if (x2_k_delayed_minus_1 && first_m1 < 0) first_m1 = i;
    end
    check_eq("t1_dly_latency", 32'(first_d), 32'd33);
    check_eq("t1_m1_latency", 32'(first_m1), 32'd34);
    check_eq("t1_clr_held", 32'(ccd_clr), 32'd1);
    check_eq("t1_tap_held", 32'(tap), 32'd32);

    // 2: sign tied 0, tap climbs to 62 then saturates
    x2_k = 1'b1;
    en   = 1'b1;
    tick();
    check_eq("t2_clear", 32'(ccd_clr), 32'd1);
    check_eq("t2_tap0", 32'(tap), 32'd32);
    for (int w = 1; w <= 32; w++) begin
      run_window(1'b0, (32 + w > 62) ? 62 : 32 + w, logic'(32 + w > 62), 1'b0, "t2_up");
    end

    // 3: sign tied 1, tap walks down to 0 then saturates
    for (int w = 1; w <= 64; w++) begin
      run_window(1'b1, (62 - w < 0) ? 0 : 62 - w, logic'(62 - w < 0), 1'b0, "t3_down");
    end

    // 4: alternating sign from reset, lock after 8 reversals, unlock on a repeat
    do_reset();
    en = 1'b1;
    tick();
    check_eq("t4_clear", 32'(ccd_clr), 32'd1);
    for (int w = 1; w <= 12; w++) begin
      run_window(logic'(w % 2 == 0), (w % 2 == 1) ? 33 : 32, 1'b0, logic'(w >= 10), "t4_alt");
    end
    run_window(1'b1, 31, 1'b0, 1'b1, "t4_repeat");
    run_window(1'b0, 32, 1'b0, 1'b0, "t4_unlocked");

    // 5: relock, then drop en mid-DWELL
    for (int w = 15; w <= 21; w++) begin
      run_window(logic'(w % 2 == 1), (w % 2 == 1) ? 31 : 32, 1'b0, 1'b0, "t5_relock");
    end
    ccd_sign = 1'b0;
    tick();
    tick();
    check_eq("t5_locked_before", 32'(locked), 32'd1);
    en = 1'b0;
    tick();
    check_eq("t5_idle_clr", 32'(ccd_clr), 32'd1);
    check_eq("t5_idle_locked", 32'(locked), 32'd0);
    check_eq("t5_idle_tap", 32'(tap), 32'd31);
    tick();
    tick();
    tick();
    check_eq("t5_hold_tap", 32'(tap), 32'd31);
    check_eq("t5_hold_clr", 32'(ccd_clr), 32'd1);
    en = 1'b1;
    tick();
    check_eq("t5_reen_clear", 32'(ccd_clr), 32'd1);
    run_window(1'b0, 32, 1'b0, 1'b0, "t5_reen");

    // 6: climb to tap 40, then reset mid-DWELL
    for (int w = 1; w <= 8; w++) begin
      run_window(1'b0, 32 + w, 1'b0, 1'b0, "t6_up");
    end
    tick();
    tick();
    check_eq("t6_pre_dly", 32'(x2_k_delayed), 32'd1);
    check_eq("t6_pre_m1", 32'(x2_k_delayed_minus_1), 32'd1);
    check_eq("t6_pre_tap", 32'(tap), 32'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    check_eq("t6_rst_tap", 32'(tap), 32'd32);
    check_eq("t6_rst_dly", 32'(x2_k_delayed), 32'd0);
    check_eq("t6_rst_m1", 32'(x2_k_delayed_minus_1), 32'd0);
    check_eq("t6_rst_clr", 32'(ccd_clr), 32'd1);
    check_eq("t6_rst_locked", 32'(locked), 32'd0);
    first_d  = -1;
    first_m1 = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (x2_k_delayed && first_d < 0) first_d = i;
      if (x2_k_delayed_minus_1 && first_m1 < 0) first_m1 = i;
    end
    check_eq("t6_refill_dly", 32'(first_d), 32'd34);
    check_eq("t6_refill_m1", 32'(first_m1), 32'd35);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
